// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and defaults for the push-button debouncer
//
// Purpose : FSM state type, default tick counts and synchronizer depth
//           shared by btn_debouncer and sync_edge.
// Ports   : none (package)
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   localparam int DEF_DEBOUNCE_TICKS = 4;    // ~31 ms at 128 Hz
   localparam int DEF_REPEAT_DELAY   = 64;   // 0.5 s before first repeat
   localparam int DEF_REPEAT_PERIOD  = 16;   // 125 ms between repeats
   localparam int DEF_CNT_W          = 8;
   localparam int SYNC_STAGES        = 2;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - synchronizer with rising-edge pulse for the divider strobe
//
// Purpose : brings the 128 Hz divider output into clk and turns each rising
//           edge into a single-clk pulse.
// Ports   : clk  - system clock
//           rst  - asynchronous reset, active-high
//           din  - asynchronous level input
//           rise - one-clk pulse per rising edge of the synchronized level
module sync_edge
   import btn_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sr;
   logic                   prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr   <= '0;
         prev <= 1'b0;
      end else begin
         sr   <= {sr[SYNC_STAGES-2:0], din};
         prev <= sr[SYNC_STAGES-1];
      end
   end

   assign rise = sr[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - push-button debouncer sampling on the 128 Hz divider strobe
//
// Purpose : accepts a level change only after DEBOUNCE_TICKS consecutive
//           agreeing samples, taken on rising edges of the divider output.
//           Optional macro BTN_AUTOREPEAT_EN adds auto-repeat press pulses
//           while the button stays held.
// Ports   : clk         - 50 MHz system clock
//           rst         - asynchronous reset, active-high
//           btn_raw     - raw bouncing button, 1 = pressed
//           tick_in     - 128 Hz square wave from the divider (0 while disabled)
//           div_en      - divider enable
//           btn_level   - debounced level
//           btn_press   - one-clk pulse on accepted press (and on repeats)
//           btn_release - one-clk pulse on accepted release
module btn_debouncer
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
)(
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic tick_in,
   output logic div_en,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   // Counter stops at the largest target it ever has to reach, so it cannot wrap.
   localparam int CNT_MAX =
      (DEBOUNCE_TICKS > REPEAT_DELAY)
         ? ((DEBOUNCE_TICKS > REPEAT_PERIOD) ? DEBOUNCE_TICKS : REPEAT_PERIOD)
         : ((REPEAT_DELAY   > REPEAT_PERIOD) ? REPEAT_DELAY   : REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] DB_TGT  = CNT_W'(DEBOUNCE_TICKS);

   btn_state_t             state, state_nx;
   logic [CNT_W-1:0]       cnt, cnt_nx, cnt_inc;
   logic                   level_nx, press_nx, release_nx;
   logic [SYNC_STAGES-1:0] btn_sr;
   logic                   btn_s;
   logic                   tick;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_DLY = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] REP_PER = CNT_W'(REPEAT_PERIOD);
   // Set once the first repeat has fired; later repeats use the shorter period.
   logic rep_on, rep_on_nx;
`endif

   sync_edge u_tick_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (tick_in),
      .rise (tick)
   );

   assign btn_s   = btn_sr[SYNC_STAGES-1];
   assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_sr      <= '0;
         state       <= IDLE;
         cnt         <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rep_on      <= 1'b0;
`endif
      end else begin
         btn_sr      <= {btn_sr[SYNC_STAGES-2:0], btn_raw};
         state       <= state_nx;
         cnt         <= cnt_nx;
         btn_level   <= level_nx;
         btn_press   <= press_nx;
         btn_release <= release_nx;
`ifdef BTN_AUTOREPEAT_EN
         rep_on      <= rep_on_nx;
`endif
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      level_nx   = btn_level;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      div_en     = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_on_nx  = rep_on;
`endif
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (btn_s) state_nx = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            div_en = 1'b1;
            if (tick) begin
               if (!btn_s) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else if (cnt_inc == DB_TGT) begin
                  state_nx = PRESSED;
                  cnt_nx   = '0;
                  level_nx = 1'b1;
                  press_nx = 1'b1;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
         end
         PRESSED: begin
`ifdef BTN_AUTOREPEAT_EN
            div_en = 1'b1;
            if (!btn_s) begin
               state_nx  = RELEASE_WAIT;
               cnt_nx    = '0;
               rep_on_nx = 1'b0;
            end else if (tick) begin
               if (cnt_inc == (rep_on ? REP_PER : REP_DLY)) begin
                  press_nx  = 1'b1;
                  cnt_nx    = '0;
                  rep_on_nx = 1'b1;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
`else
            if (!btn_s) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = '0;
            end
`endif
         end
         RELEASE_WAIT: begin
            div_en = 1'b1;
            if (tick) begin
               if (btn_s) begin
                  state_nx = PRESSED;
                  cnt_nx   = '0;
               end else if (cnt_inc == DB_TGT) begin
                  state_nx   = IDLE;
                  cnt_nx     = '0;
                  level_nx   = 1'b0;
                  release_nx = 1'b1;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_btn_debouncer.sv
// tb/tb_btn_debouncer.sv - self-checking bench for btn_debouncer
module tb_btn_debouncer;

   localparam int DT   = 4;
   localparam int RD   = 64;
   localparam int RP   = 16;
   localparam int HALF = 20;   // divider half period in clks (time-scaled)
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_raw = 1'b0;
   logic tick_in = 1'b0;
   logic div_en, btn_level, btn_press, btn_release;

   int checks = 0;
   int errors = 0;
   int press_cnt = 0;
   int rel_cnt = 0;
   int ticks_seen = 0;
   bit tin_prev = 1'b0;

   // reference model state: accepted level, "waiting" flag, run of
   // disagreeing tick samples, ticks held since acceptance
   bit m_lvl, m_busy, exp_press, exp_rel;
   int m_run, m_held;
   bit raw_h0, raw_h1, tin_h0, tin_h1, tin_h2;

   btn_debouncer dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .tick_in     (tick_in),
      .div_en      (div_en),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // divider: low for HALF clks after enable, then a square wave
   initial begin
      int dcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!div_en) begin
            dcnt    = 0;
            tick_in = 1'b0;
         end else begin
            dcnt++;
            tick_in = ((dcnt % (2*HALF)) >= HALF);
         end
      end
   end

   // reference model: the design sees inputs two clks late; a sample is the
   // delayed button on a delayed rising edge of tick_in
   initial begin
      bit b, tk;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_lvl = 0; m_busy = 0; m_run = 0; m_held = 0;
            exp_press = 0; exp_rel = 0;
            raw_h0 = 0; raw_h1 = 0; tin_h0 = 0; tin_h1 = 0; tin_h2 = 0;
         end else begin
            b  = raw_h1;
            tk = tin_h1 & ~tin_h2;
            exp_press = 0;
            exp_rel   = 0;
            if (!m_busy) begin
               if (b != m_lvl) begin
                  m_busy = 1; m_run = 0; m_held = 0;
               end else if (AR && m_lvl && tk) begin
                  m_held++;
                  if (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0))
                     exp_press = 1;
               end
            end else if (tk) begin
               if (b == m_lvl) begin
                  m_busy = 0; m_run = 0; m_held = 0;
               end else begin
                  m_run++;
                  if (m_run == DT) begin
                     m_lvl = b; m_busy = 0; m_run = 0; m_held = 0;
                     exp_press = b;
                     exp_rel   = !b;
                  end
               end
            end
            raw_h1 = raw_h0; raw_h0 = btn_raw;
            tin_h2 = tin_h1; tin_h1 = tin_h0; tin_h0 = tick_in;
         end
      end
   end

   // per-cycle compare and pulse/tick monitors
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("cyc_level",   btn_level,   m_lvl);
            check("cyc_press",   btn_press,   exp_press);
            check("cyc_release", btn_release, exp_rel);
            check("cyc_div_en",  div_en,      m_busy | (AR & m_lvl));
         end
         press_cnt += btn_press;
         rel_cnt   += btn_release;
         if (tick_in && !tin_prev) ticks_seen++;
         tin_prev = tick_in;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_pulse(input bit rel, input int budget, input string name);
      bit found = 0;
      for (int i = 0; i < budget && !found; i++) begin
         @(posedge clk);
         #1;
         found = rel ? btn_release : btn_press;
      end
      check(name, found, 1);
      #1;
   endtask

   initial begin
      // 1: reset with button held
      btn_raw = 1'b1;
      step(5);
      #3;
      check("rst_level", btn_level, 0);
      check("rst_press", btn_press, 0);
      check("rst_release", btn_release, 0);
      check("rst_div_en", div_en, 0);
      step(1);
      rst = 1'b0;
      @(posedge clk); #1; check("den_clk1", div_en, 0);
      @(posedge clk); #1; check("den_clk2", div_en, 0);
      @(posedge clk); #1; check("den_clk3", div_en, 1);
      #1;
      ticks_seen = 0;
      wait_pulse(0, 400, "t1_press_timeout");
      check("t1_ticks_at_press", ticks_seen, 4);
      step(2);
      check("t1_level", btn_level, 1);
      check("t1_press_cnt", press_cnt, 1);

      // 3: clean release
      btn_raw = 1'b0;
      wait_pulse(1, 600, "t3_release_timeout");
      step(5);
      check("t3_press_cnt", press_cnt, 1);
      check("t3_rel_cnt", rel_cnt, 1);
      check("t3_level", btn_level, 0);
      check("t3_div_en", div_en, 0);

      // 2: press aborted after two high samples
      press_cnt = 0; rel_cnt = 0; ticks_seen = 0;
      btn_raw = 1'b1;
      for (int i = 0; i < 400 && ticks_seen < 2; i++) step(1);
      check("t2_two_ticks", ticks_seen, 2);
      btn_raw = 1'b0;
      step(200);
      check("t2_press_cnt", press_cnt, 0);
      check("t2_level", btn_level, 0);
      check("t2_div_en", div_en, 0);

      // 4: bouncing between ticks, high at every sample
      press_cnt = 0;
      for (int i = 0; i < 800 && press_cnt == 0; i++) begin
         step(1);
         btn_raw = tick_in ? 1'b1 : ((i / 3) % 2 == 1);
      end
      check("t4_press_cnt", press_cnt, 1);
      btn_raw = 1'b0;
      wait_pulse(1, 600, "t4_release_timeout");
      step(5);

      // 5: long hold
      press_cnt = 0;
      btn_raw = 1'b1;
      wait_pulse(0, 400, "t5_accept_timeout");
      step(200 * 2 * HALF);
      check("t5_press_cnt", press_cnt, AR ? 10 : 1);
      btn_raw = 1'b0;
      wait_pulse(1, 600, "t5_release_timeout");
      step(5);

      // 6: reset during release debounce
      btn_raw = 1'b1;
      wait_pulse(0, 400, "t6_accept_timeout");
      btn_raw = 1'b0;
      step(3);
      ticks_seen = 0;
      for (int i = 0; i < 400 && ticks_seen < 2; i++) step(1);
      step(4);
      check("t6_in_release_wait", btn_level, 1);
      #1;
      rst = 1'b1;
      #1;
      check("t6_rst_level", btn_level, 0);
      check("t6_rst_press", btn_press, 0);
      check("t6_rst_release", btn_release, 0);
      check("t6_rst_div_en", div_en, 0);
      rel_cnt = 0; press_cnt = 0;
      step(3);
      rst = 1'b0;
      step(300);
      check("t6_rel_cnt", rel_cnt, 0);
      check("t6_press_cnt", press_cnt, 0);
      check("t6_level", btn_level, 0);
      check("t6_div_en", div_en, 0);

      // randomized bursts: bounce, then hold a random level
      for (int k = 0; k < 24; k++) begin
         bit tgt = 1'($urandom % 2);
         int nb = $urandom_range(0, 30);
         int nh = $urandom_range(20, 400);
         for (int i = 0; i < nb; i++) begin
            btn_raw = 1'($urandom % 2);
            step(1);
         end
         btn_raw = tgt;
         step(nh);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

endmodule
